// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode encodings, FSM state
// type and the iteration-counter width helper.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of a counter able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply, one multiplier bit per cycle.
// With ALU_MULTICYCLE_DIV_EN defined it also performs unsigned restoring
// division (quotient or remainder), one quotient bit per cycle.
// start_i loads the operands; done_o is high in the last working cycle and
// result_o then carries the final value, so the caller latches it on the
// same edge that retires the last iteration.
module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef ALU_MULTICYCLE_DIV_EN
  input  logic [3:0]       op_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  import alu_pkg::*;

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_nxt;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign done_o  = busy && (cnt == LAST);

  // Iteration control: counts WIDTH working cycles after a start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start_i) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == LAST) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Multiply datapath: add the shifted multiplicand when the current multiplier bit is set.
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      acc    <= '0;
      mcand  <= a_i;
      mplier <= b_i;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
    end
  end

`ifdef ALU_MULTICYCLE_DIV_EN
  logic             is_div;
  logic             is_rem;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // A zero divisor always "fits", giving an all-ones quotient and a remainder
  // equal to the dividend without any special casing.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvsr};
  assign ge      = ~diff[WIDTH];
  assign rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ge};

  // Divide datapath: quotient register doubles as the dividend shifter.
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      is_div <= (op_i == OP_DIVU) || (op_i == OP_REMU);
      is_rem <= (op_i == OP_REMU);
      rem    <= '0;
      quo    <= a_i;
      dvsr   <= b_i;
    end else if (busy) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  assign result_o = !is_div ? acc_nxt : (is_rem ? rem_nxt : quo_nxt);
`else
  assign result_o = acc_nxt;
`endif

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes on both sides.
// Logic/add/compare opcodes complete in one cycle; MUL (and DIVU/REMU when
// ALU_MULTICYCLE_DIV_EN is defined) run WIDTH cycles in alu_iter_unit.
// One operation is in flight at a time; the result is held until consumed.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  input  logic             ready_i
);
  import alu_pkg::*;

  state_t           state;
  logic             accept;
  logic             iter_op;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] quick_result;

  // Single-cycle operations; anything not listed (including MUL and the
  // divide codes) yields zero here.
  function automatic logic [WIDTH-1:0] quick_alu(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: r = WIDTH'(a < b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_MULTICYCLE_DIV_EN
  assign iter_op = (ctrl_i == OP_MUL) || (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);
`else
  assign iter_op = (ctrl_i == OP_MUL);
`endif

  assign ready_o      = (state == S_IDLE);
  assign accept       = valid_i && ready_o;
  assign iter_start   = accept && iter_op;
  assign quick_result = quick_alu(ctrl_i, src1_i, src2_i);

  alu_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (iter_start),
`ifdef ALU_MULTICYCLE_DIV_EN
    .op_i    (ctrl_i),
`endif
    .a_i     (src1_i),
    .b_i     (src2_i),
    .done_o  (iter_done),
    .result_o(iter_result)
  );

  // Control FSM with registered result/zero/valid outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      valid_o  <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (iter_op) begin
              state <= S_BUSY;
            end else begin
              result_o <= quick_result;
              zero_o   <= (quick_result == '0);
              valid_o  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (iter_done) begin
            result_o <= iter_result;
            zero_o   <= (iter_result == '0);
            valid_o  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32). A transaction-level
// reference model predicts result/zero/valid/ready every cycle; directed
// operations additionally check hand-computed values and latencies.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic [3:0]   ctrl_i = 4'd0;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         valid_o;
  logic         ready_i = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int bp_mode = 0;   // 0: always ready, 1: random stalls, 2: never ready
  bit junk    = 1'b0;
  bit chk_en  = 1'b0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .ctrl_i  (ctrl_i),
    .result_o(result_o),
    .zero_o  (zero_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return W'(a * b);
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd8:  return (a < b) ? W'(1) : W'(0);
      4'd12: return ~(a | b);
      4'd13: return a ^ b;
`ifdef ALU_MULTICYCLE_DIV_EN
      4'd4:  return (b == 0) ? {W{1'b1}} : a / b;
      4'd5:  return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c);
`ifdef ALU_MULTICYCLE_DIV_EN
    if (c == 4'd3 || c == 4'd4 || c == 4'd5) return W + 1;
`else
    if (c == 4'd3) return W + 1;
`endif
    return 1;
  endfunction

  // Model state: a held result, or an operation counting down its latency.
  bit           m_valid = 1'b0;
  bit           m_busy  = 1'b0;
  int           m_cnt   = 0;
  logic [W-1:0] m_res   = '0;
  logic         m_zero  = 1'b1;
  logic [W-1:0] m_pres  = '0;

  always @(posedge clk) begin
    logic [W-1:0] r;
    int l;
    if (rst_i) begin
      m_valid = 1'b0; m_busy = 1'b0; m_cnt = 0; m_res = '0; m_zero = 1'b1;
    end else if (m_valid) begin
      if (ready_i) m_valid = 1'b0;
    end else if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_valid = 1'b1; m_res = m_pres; m_zero = (m_pres == 0);
      end
    end else if (valid_i) begin
      r = ref_alu(ctrl_i, src1_i, src2_i);
      l = ref_lat(ctrl_i);
      if (l == 1) begin
        m_valid = 1'b1; m_res = r; m_zero = (r == 0);
      end else begin
        m_busy = 1'b1; m_cnt = l - 1; m_pres = r;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mon_valid", valid_o, m_valid);
      check("mon_ready", ready_o, !m_valid && !m_busy);
      check("mon_result", result_o, m_res);
      check("mon_zero", zero_o, m_zero);
    end
  end

  // Consumer back-pressure, changed away from both clock edges.
  always @(posedge clk) begin
    #2;
    if (bp_mode == 1) ready_i = ($urandom_range(0, 3) != 0);
    else if (bp_mode == 2) ready_i = 1'b0;
    else ready_i = 1'b1;
  end

  // ---------------- stimulus tasks ----------------
  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic accept_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string nm, output bit ok);
    int k;
    k = 0;
    ok = 1'b1;
    while (!ready_o && k < 200) begin
      valid_i = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      src1_i  = $urandom;
      src2_i  = $urandom;
      ctrl_i  = 4'($urandom_range(0, 15));
      @(negedge clk);
      k++;
    end
    if (!ready_o) begin
      check({nm, "_ready_timeout"}, ready_o, 1);
      valid_i = 1'b0;
      ok = 1'b0;
      return;
    end
    valid_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    src1_i  = $urandom;
    src2_i  = $urandom;
    ctrl_i  = 4'($urandom_range(0, 15));
  endtask

  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit lit, input logic [W-1:0] er, input int el, input string nm);
    int k;
    bit ok;
    accept_op(c, a, b, nm, ok);
    if (!ok) return;
    k = 1;
    while (!valid_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!valid_o) begin
      check({nm, "_valid_timeout"}, valid_o, 1);
      return;
    end
    if (lit) begin
      check({nm, "_latency"}, k, el);
      check({nm, "_result"}, result_o, er);
      check({nm, "_zero"}, zero_o, (er == 0));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return {W{1'b1}};
      3: return {1'b1, {(W-1){1'b0}}};
      4: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    bit ok;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    check("reset_valid", valid_o, 0);
    check("reset_ready", ready_o, 1);
    check("reset_result", result_o, 0);
    check("reset_zero", zero_o, 1);
    chk_en = 1'b1;

    // Pin the model with hand-computed values.
    check("pin_add_ovf", ref_alu(4'd2, 32'h7FFF_FFFF, 32'd1), 32'h8000_0000);
    check("pin_slt", ref_alu(4'd7, 32'hFFFF_FFFF, 32'd1), 1);
    check("pin_sltu", ref_alu(4'd8, 32'hFFFF_FFFF, 32'd1), 0);
    check("pin_mul", ref_alu(4'd3, 32'd7, 32'd6), 42);
    check("pin_mul_wrap", ref_alu(4'd3, 32'h0001_0000, 32'h0001_0000), 0);
    check("pin_mul_lat", ref_lat(4'd3), 33);

    // Directed operations.
    run_op(4'd2,  32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1, "add_ovf");
    run_op(4'd2,  32'hFFFF_FFFF, 32'd1, 1, 32'h0, 1, "add_wrap");
    run_op(4'd7,  32'hFFFF_FFFF, 32'd1, 1, 32'h1, 1, "slt");
    run_op(4'd8,  32'hFFFF_FFFF, 32'd1, 1, 32'h0, 1, "sltu");
    run_op(4'd3,  32'h0001_0000, 32'h0001_0000, 1, 32'h0, 33, "mul_wrap");
    run_op(4'd3,  32'd7, 32'd6, 1, 32'd42, 33, "mul_small");
    run_op(4'd6,  32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1, "sub_neg");
    run_op(4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 1, "and");
    run_op(4'd1,  32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F, 1, "or");
    run_op(4'd12, 32'h0F0F_0F0F, 32'h00FF_00FF, 1, 32'hF000_F000, 1, "nor");
    run_op(4'd13, 32'h0F0F_0F0F, 32'h00FF_00FF, 1, 32'h0FF0_0FF0, 1, "xor");
    run_op(4'd15, 32'd9, 32'd9, 1, 32'h0, 1, "unsupported");
`ifdef ALU_MULTICYCLE_DIV_EN
    run_op(4'd4, 32'd100, 32'd7, 1, 32'd14, 33, "divu");
    run_op(4'd5, 32'd100, 32'd7, 1, 32'd2, 33, "remu");
    run_op(4'd4, 32'd123, 32'd0, 1, 32'hFFFF_FFFF, 33, "divu_by0");
    run_op(4'd5, 32'd123, 32'd0, 1, 32'd123, 33, "remu_by0");
`else
    run_op(4'd4, 32'd100, 32'd7, 1, 32'h0, 1, "divu_off");
    run_op(4'd5, 32'd100, 32'd7, 1, 32'h0, 1, "remu_off");
`endif

    // Back-pressure: result held while the consumer stalls, new requests ignored.
    bp_mode = 2;
    @(negedge clk);
    run_op(4'd2, 32'd10, 32'd20, 1, 32'd30, 1, "bp_add");
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; ctrl_i = 4'd2; src1_i = $urandom; src2_i = $urandom;
      @(negedge clk);
      check("bp_hold_valid", valid_o, 1);
      check("bp_hold_result", result_o, 32'd30);
      check("bp_hold_ready", ready_o, 0);
    end
    valid_i = 1'b0;
    bp_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_ready", ready_o, 1);
    check("bp_release_valid", valid_o, 0);

    // Reset in the middle of a multiply aborts it.
    accept_op(4'd3, 32'h1234, 32'h5678, "rst_mul", ok);
    repeat (9) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    check("rst_mul_no_valid", seen, 0);
    check("rst_mul_result", result_o, 0);
    check("rst_mul_zero", zero_o, 1);
    check("rst_mul_ready", ready_o, 1);
    run_op(4'd2, 32'd2, 32'd3, 1, 32'd5, 1, "add_after_rst");

    // Randomized traffic with stalls and ignored requests.
    bp_mode = 1;
    junk = 1'b1;
    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), 0, '0, 0, "rand");
    end
    junk = 1'b0;
    valid_i = 1'b0;
    bp_mode = 0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Port: clk_i  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst_i  input  1  reset; synchronous, active-high.
REQ-004 Port: valid_i  input  1  request valid.
REQ-005 Port: ready_o  output  1  block can accept a request this cycle.
REQ-006 Port: src1_i  input  WIDTH  first operand.
REQ-007 Port: src2_i  input  WIDTH  second operand.
REQ-008 Port: ctrl_i  input  4  operation select.
REQ-009 Port: result_o  output  WIDTH  operation result.
REQ-010 Port: zero_o  output  1  high when result_o == 0.
REQ-011 Port: valid_o  output  1  result_o/zero_o valid.
REQ-012 Port: ready_i  input  1  consumer accepts result.

Function
REQ-013 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 MUL (low WIDTH bits), 0110 SUB, 0111 SLT signed, 1000 SLTU unsigned, 1100 NOR, 1101 XOR; any other code SHALL yield result 0, zero 1.
REQ-014 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-015 SLT/SLTU SHALL yield 1 or 0 zero-extended to WIDTH.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE.
REQ-017 Request SHALL be accepted on a cycle with valid_i && ready_o; operands and ctrl_i latched that cycle; later input changes ignored.
REQ-018 ready_o SHALL be high only in IDLE.
REQ-019 Single-cycle opcodes: IDLE -> DONE; valid_o high the cycle after acceptance (latency 1).
REQ-020 MUL: IDLE -> BUSY; iterative shift-add, one bit per cycle, WIDTH cycles in BUSY, then DONE; valid_o rises exactly WIDTH+1 cycles after acceptance.
REQ-021 DONE SHALL hold result_o, zero_o, valid_o stable until ready_i is high; DONE -> IDLE on that cycle.
REQ-022 valid_o high with ready_i high SHALL return to IDLE; no back-to-back acceptance in the same cycle (max throughput one op per 2 cycles).
REQ-023 valid_i while not in IDLE SHALL be ignored (no queuing).
REQ-024 Outside DONE, valid_o SHALL be 0; result_o/zero_o retain last completed value.

Reset
REQ-025 On rst_i high at a clock edge: state IDLE, valid_o 0, result_o 0, zero_o 1, iteration counter 0.
REQ-026 Reset in BUSY or DONE SHALL abort the operation; the result is discarded, ready_o high the cycle after rst_i deasserts.

Configuration
REQ-027 Macro ALU_MULTICYCLE_DIV_EN, when defined, SHALL add 0100 DIVU and 0101 REMU (unsigned restoring division, WIDTH BUSY cycles, latency WIDTH+1).
REQ-028 With ALU_MULTICYCLE_DIV_EN, division by zero SHALL give DIVU all-ones, REMU = src1; same latency.
REQ-029 Without the macro, 0100/0101 SHALL behave as unsupported codes (result 0, zero 1, latency 1) and no divider logic SHALL exist.

Structure
REQ-030 Package alu_pkg SHALL hold opcode constants, FSM state typedef, and counter-width function $clog2(WIDTH+1).
REQ-031 Iterative datapath SHALL be sub-module alu_iter_unit (shift-add multiply, optional restoring divide), with start/done handshake to the FSM.

Verification
REQ-032 WIDTH=32, ADD 0x7FFFFFFF+1, ready_i=1 -> valid_o cycle+1, result 0x80000000, zero 0; ADD 0xFFFFFFFF+1 -> result 0, zero 1.
REQ-033 SLT src1=0xFFFFFFFF, src2=1 -> 1; SLTU same operands -> 0.
REQ-034 MUL 0x00010000*0x00010000 -> result 0, zero 1, valid_o exactly 33 cycles after acceptance; 7*6 -> 42.
REQ-035 Back-pressure: ready_i=0 for 5 cycles after DONE -> result/valid_o stable, ready_o low, new valid_i ignored; ready_i=1 -> ready_o high next cycle.
REQ-036 rst_i pulsed at BUSY cycle 10 of MUL -> valid_o never rises for it, result 0, zero 1, next ADD 2+3 returns 5.
REQ-037 With ALU_MULTICYCLE_DIV_EN: DIVU 100/7 -> 14, REMU -> 2, DIVU x/0 -> 0xFFFFFFFF; without macro, DIVU -> 0 at latency 1.
